inc_dec_seq_ctrl: RTL
=====================

# inc_dec_seq_ctrl

Sequencer that drives the `inc`/`dec` inputs of the 4-bit `inc_dec_counter` to move it to a commanded target value. It issues single-cycle step pulses separated by a programmable idle gap and tracks a shadow copy of the counter value. It reports completion through a start/busy/done handshake. It sits between a host command source and the counter, and is the only driver of the counter's `inc`/`dec`.

## Interface
- `WIDTH`, default 4: counter and target width.
- `GAP_CYCLES`, default 2: number of idle cycles between consecutive step pulses; legal range 1..15.

Ports:
- `clk` input, 1: single clock; all logic on the rising edge.
- `rst` input, 1: asynchronous, active-high reset. It is shared with the counter.
- `start` input, 1: command strobe; sampled only in IDLE.
- `target` input, WIDTH: destination value; latched when `start` is accepted.
- `abort` input, 1: stops the sequence after the current step; sampled in PULSE and GAP only.
- `inc` output, 1: registered increment pulse to the counter.
- `dec` output, 1: registered decrement pulse to the counter.
- `cur` output, WIDTH: shadow counter value.
- `busy` output, 1: high in PULSE and GAP.
- `done` output, 1: one-cycle completion strobe.
- `aborted` output, 1: valid with `done`; 1 means the sequence ended on `abort`.

## Operation
States are IDLE, PULSE, GAP and DONE.

- **Reset values:** state IDLE; `inc`, `dec`, `busy`, `done` and `aborted` all 0; `cur` = 0, matching the counter's reset value.
- **IDLE:**
  - `start`=1 latches `target` into `tgt`.
  - If `tgt` == `cur`, next state is DONE with `aborted`=0 and no pulse is issued.
  - Otherwise next state is PULSE. Direction is up if `tgt` > `cur`, else down (unsigned compare, no wrap path).
- **PULSE:**
  - Exactly one of `inc`/`dec` is high for this single cycle.
  - At the closing edge, `cur` becomes `cur`+1 or `cur`−1.
  - Next state is DONE if the new `cur` == `tgt` or `abort`=1. Otherwise next state is GAP with the gap counter loaded to GAP_CYCLES−1.
- **GAP:**
  - `inc` and `dec` are 0.
  - `abort`=1 sends the FSM to DONE.
  - When the gap counter reaches 0, the next state is PULSE; otherwise the counter decrements.
- **DONE:**
  - `done`=1 for one cycle, and `aborted` reflects the cause.
  - Next state is IDLE.
  - `start` in DONE is ignored.
- **Output rules:**
  - `inc` and `dec` are never high together.
  - `cur` never leaves the range 0..2^WIDTH−1, because the direction always points toward `tgt`.
- **Ignored inputs:**
  - `start` while `busy` or in DONE is ignored, and `target` changes after acceptance have no effect.
  - `abort` in IDLE or DONE is ignored.
  - If `start` and `abort` are both high in IDLE, `start` is accepted.
- **Abort during PULSE:** the pulse already on the output completes and `cur` is updated; there is no partial step.
- **Reset mid-operation:** all outputs clear immediately, without waiting for a clock edge. The counter resets on the same `rst`, so `cur` stays consistent with it.

## Timing
- Cycle 0 is the edge at which `start` is sampled in IDLE.
- **Steps:** for a distance d = |`tgt`−`cur`| > 0 and gap G = GAP_CYCLES:
  - Step pulse k (k = 0..d−1) is high during cycle 1 + k(G+1).
  - `done` is high in cycle d(G+1) − G + 1.
  - `busy` is high from cycle 1 through the last pulse cycle inclusive.
- **d = 0:** `done` is high in cycle 1 and `busy` never asserts.
- **Counter alignment:** `inc`/`dec` change only on rising edges. The counter samples each pulse at the edge that closes the pulse cycle, which is the same edge at which `cur` updates. `cur` therefore equals the counter's `cnt` every cycle.
- **Next command:** the earliest next `start` is accepted in the cycle after `done`.

## Test plan
1. **Count up:** reset, then `start` with `target`=3 at G=2.
   - `inc` pulses in cycles 1, 4 and 7; `dec` stays 0.
   - `done`=1 in cycle 8 with `aborted`=0.
   - `cur`=3, matching the counter's `cnt`=3.
2. **Count down:** from `cur`=10, `start` with `target`=5.
   - Five `dec` pulses spaced 3 cycles apart.
   - `done` in cycle 14; `cur`=5; `inc` never asserts.
3. **Zero distance:** `start` with `target` equal to `cur`=5.
   - `done`=1 in cycle 1 with `aborted`=0.
   - No `inc`/`dec` pulse and `busy` stays 0.
4. **Abort:** from 0, `start` with `target`=15, then `abort`=1 in cycle 5 (during GAP after the second pulse).
   - `done` in cycle 6 with `aborted`=1.
   - `cur`=2; no further pulses.
   - A second case asserts `abort` during a PULSE cycle: that step still completes.
5. **Ignored inputs:** `start` with `target`=0 while `busy` on a run toward 15.
   - The run still ends at `cur`=15.
   - `abort` asserted in IDLE has no effect.
   - `start` and `abort` together in IDLE: the run starts normally.
6. **Reset mid-operation:** assert `rst` asynchronously mid-run (between clock edges), during a cycle where `inc` is high and the FSM is in PULSE.
   - `inc`, `busy` and `done` go to 0 and `cur` goes to 0 immediately.
   - After release, `start` with `target`=1 completes normally in cycle 2.

Source files
------------

// File: rtl/inc_dec_seq_ctrl_if.sv
// Command/status bundle between the host and the inc/dec sequencer.
// The host side is master and the sequencer side is slave.
interface inc_dec_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] target;
  logic             abort;
  logic             inc;
  logic             dec;
  logic [WIDTH-1:0] cur;
  logic             busy;
  logic             done;
  logic             aborted;

  modport master (
    output start, target, abort,
    input  inc, dec, cur, busy, done, aborted
  );

  modport slave (
    input  start, target, abort,
    output inc, dec, cur, busy, done, aborted
  );
endinterface

// File: rtl/inc_dec_seq_ctrl.sv
// Steps an external inc/dec counter toward a commanded target, one pulse at a time,
// with GAP_CYCLES idle cycles between pulses and a shadow copy of the counter value.
module inc_dec_seq_ctrl #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  inc_dec_seq_ctrl_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] tgt_reg, tgt_next;
  logic [WIDTH-1:0] cur_reg, cur_next;
  logic             up_reg, up_next;
  logic [3:0]       gap_reg, gap_next;
  logic             inc_reg, inc_next;
  logic             dec_reg, dec_next;
  logic             done_reg, done_next;
  logic             aborted_reg, aborted_next;
  logic [WIDTH-1:0] step_cur;

  // Value the shadow takes at the edge closing a pulse cycle.
  assign step_cur = up_reg ? cur_reg + WIDTH'(1) : cur_reg - WIDTH'(1);

  always_comb begin
    state_next   = state_reg;
    tgt_next     = tgt_reg;
    cur_next     = cur_reg;
    up_next      = up_reg;
    gap_next     = gap_reg;
    inc_next     = 1'b0;
    dec_next     = 1'b0;
    done_next    = 1'b0;
    aborted_next = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          tgt_next = bus.target;
          if (bus.target == cur_reg) begin
            state_next = S_DONE;
            done_next  = 1'b1;
          end else begin
            state_next = S_PULSE;
            up_next    = (bus.target > cur_reg);
            inc_next   = (bus.target > cur_reg);
            dec_next   = !(bus.target > cur_reg);
          end
        end
      end
      S_PULSE: begin
        cur_next = step_cur;
        if ((step_cur == tgt_reg) || bus.abort) begin
          state_next = S_DONE;
          done_next  = 1'b1;
          // Reaching the target on the aborted step still counts as a normal finish.
          aborted_next = (step_cur != tgt_reg);
        end else begin
          state_next = S_GAP;
          gap_next   = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (bus.abort) begin
          state_next   = S_DONE;
          done_next    = 1'b1;
          aborted_next = 1'b1;
        end else if (gap_reg == 4'd0) begin
          state_next = S_PULSE;
          inc_next   = up_reg;
          dec_next   = !up_reg;
        end else begin
          gap_next = gap_reg - 4'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      tgt_reg     <= '0;
      cur_reg     <= '0;
      up_reg      <= 1'b0;
      gap_reg     <= 4'd0;
      inc_reg     <= 1'b0;
      dec_reg     <= 1'b0;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tgt_reg     <= tgt_next;
      cur_reg     <= cur_next;
      up_reg      <= up_next;
      gap_reg     <= gap_next;
      inc_reg     <= inc_next;
      dec_reg     <= dec_next;
      done_reg    <= done_next;
      aborted_reg <= aborted_next;
    end
  end

  assign bus.inc     = inc_reg;
  assign bus.dec     = dec_reg;
  assign bus.cur     = cur_reg;
  assign bus.busy    = (state_reg == S_PULSE) || (state_reg == S_GAP);
  assign bus.done    = done_reg;
  assign bus.aborted = aborted_reg;

endmodule
